// File: rtl/clk_diag_seq.sv
// Diagnostic sequencer for the M8526 CLK board: expands one clock command
// into the ordered EBUS diagnostic function cycles (CTL, load, read), and
// for BURST polls the burst counter back until it drains or times out.
module clk_diag_seq #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic       clk,
  input  logic       FPGA_RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic [6:0] diag_ds,
  output logic       diag_strobe,
  output logic       ebus_drive,
  output logic [3:0] ebus_dout,
  output logic       diag_read,
  input  logic [5:0] ebus_din,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam int unsigned MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAXC   = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned CW     = $clog2(MAXC) + 1;
  localparam int unsigned PW     = $clog2(POLL_LIMIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_POLL_SAMPLE, S_DONE
  } state_t;

  // Which function of the current command's step list is being issued.
  typedef enum logic [2:0] {
    PH_MAIN, PH_B42, PH_B43, PH_B05, PH_P101, PH_P100, PH_STOP
  } phase_t;

  typedef enum logic [2:0] {
    OP_START, OP_STOP, OP_STEP, OP_BURST, OP_SRC_RATE, OP_CLR_RST, OP_SET_RST, OP_READ
  } op_t;

  // Everything that must stay constant across one function cycle.
  typedef struct packed {
    logic [6:0] ds;
    logic [3:0] dout;
    logic       drive;
    logic       rd;
  } fn_t;

  function automatic fn_t fn_of(phase_t ph, op_t op, logic [7:0] arg);
    fn_t f;
    f = '0;
    case (ph)
      PH_MAIN: begin
        case (op)
          OP_START:    f.ds = 7'o001;
          OP_STOP:     f.ds = 7'o000;
          OP_STEP:     f.ds = 7'o002;
          OP_SRC_RATE: begin
            f.ds    = 7'o044;
            f.dout  = arg[3:0];
            f.drive = 1'b1;
          end
          OP_CLR_RST:  f.ds = 7'o006;
          OP_SET_RST:  f.ds = 7'o007;
          OP_READ: begin
            f.ds = 7'o100 | {4'b0000, arg[2:0]};
            f.rd = 1'b1;
          end
          default:     f = '0;
        endcase
      end
      PH_B42: begin
        f.ds    = 7'o042;
        f.dout  = arg[3:0];
        f.drive = 1'b1;
      end
      PH_B43: begin
        f.ds    = 7'o043;
        f.dout  = arg[7:4];
        f.drive = 1'b1;
      end
      PH_B05: f.ds = 7'o005;
      PH_P101: begin
        f.ds = 7'o101;
        f.rd = 1'b1;
      end
      PH_P100: begin
        f.ds = 7'o100;
        f.rd = 1'b1;
      end
      PH_STOP: f.ds = 7'o000;
      default: f = '0;
    endcase
    return f;
  endfunction

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  op_t             op_q, op_d;
  logic [7:0]      arg_q, arg_d;
  fn_t             fn_q, fn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   poll_q, poll_d, poll_inc;
  logic [7:0]      samp_q, samp_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  // State and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (FPGA_RESET) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_MAIN;
      op_q       <= OP_START;
      arg_q      <= '0;
      fn_q       <= '0;
      cnt_q      <= '0;
      poll_q     <= '0;
      samp_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      fn_q       <= fn_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      samp_q     <= samp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: walks the step list one function cycle at a time.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    op_d       = op_q;
    arg_d      = arg_q;
    fn_d       = fn_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    samp_d     = samp_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    poll_inc   = (poll_q == '1) ? poll_q : poll_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          arg_d   = cmd_arg;
          phase_d = (op_t'(cmd_op) == OP_BURST) ? PH_B42 : PH_MAIN;
          fn_d    = fn_of(phase_d, op_t'(cmd_op), cmd_arg);
          cnt_d   = '0;
          poll_d  = '0;
          samp_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(STROBE_CYC - 1)) begin
          // Poll reads assemble the 8-bit count: 101 gives the low six bits
          // (data[30:35]), 100 gives the top two from data[33:34].
          if (fn_q.rd) begin
            case (phase_q)
              PH_P101: samp_d[5:0] = ebus_din;
              PH_P100: samp_d[7:6] = ebus_din[2:1];
              default: samp_d      = {2'b00, ebus_din};
            endcase
          end
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          case (phase_q)
            PH_B42: begin
              phase_d = PH_B43;
              state_d = S_NEXT;
            end
            PH_B43: begin
              if (arg_q == '0) begin
                fn_d       = '0;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = S_DONE;
              end else begin
                phase_d = PH_B05;
                state_d = S_NEXT;
              end
            end
            PH_B05: begin
              phase_d = PH_P101;
              state_d = S_NEXT;
            end
            PH_P101: begin
              phase_d = PH_P100;
              state_d = S_NEXT;
            end
            PH_P100: state_d = S_POLL_SAMPLE;
            default: begin
              fn_d       = '0;
              rsp_data_d = samp_q;
              rsp_err_d  = (phase_q == PH_STOP);
              state_d    = S_DONE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        fn_d    = fn_of(phase_q, op_q, arg_q);
        state_d = S_SETUP;
      end
      // Doubles as the single idle gap before the next poll or STOP cycle.
      S_POLL_SAMPLE: begin
        poll_d = poll_inc;
        if (samp_q == '0) begin
          fn_d       = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (poll_inc >= PW'(POLL_LIMIT)) begin
          phase_d = PH_STOP;
          fn_d    = fn_of(PH_STOP, op_q, arg_q);
          state_d = S_SETUP;
        end else begin
          phase_d = PH_P101;
          fn_d    = fn_of(PH_P101, op_q, arg_q);
          state_d = S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign diag_strobe = (state_q == S_STROBE);
  assign rsp_valid   = (state_q == S_DONE);
  assign diag_ds     = fn_q.ds;
  assign ebus_dout   = fn_q.dout;
  assign ebus_drive  = fn_q.drive;
  assign diag_read   = fn_q.rd;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_clk_diag_seq.sv
// Directed bench for clk_diag_seq with a small CLK-board counter model.
module tb_clk_diag_seq;

  logic       clk = 1'b0;
  logic       FPGA_RESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [6:0] diag_ds;
  logic       diag_strobe;
  logic       ebus_drive;
  logic [3:0] ebus_dout;
  logic       diag_read;
  logic [5:0] ebus_din;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  int checks = 0;
  int errors = 0;

  // Poll limit reduced so the timeout path completes in a few pairs.
  clk_diag_seq #(
    .SETUP_CYC (2),
    .STROBE_CYC(2),
    .HOLD_CYC  (1),
    .POLL_LIMIT(4)
  ) dut (
    .clk        (clk),
    .FPGA_RESET (FPGA_RESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .diag_ds    (diag_ds),
    .diag_strobe(diag_strobe),
    .ebus_drive (ebus_drive),
    .ebus_dout  (ebus_dout),
    .diag_read  (diag_read),
    .ebus_din   (ebus_din),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // CLK-board model: burst counter value steps through mseq after each
  // completed 100 read; stays on the last entry.
  logic [7:0] mseq [4];
  int         mlen = 1;
  int         base100 = 0;
  int         n100 = 0;
  logic       status_mode = 1'b0;
  int         midx;
  logic [7:0] cur;

  always_comb begin
    midx = n100 - base100;
    if (midx >= mlen) midx = mlen - 1;
    if (midx < 0) midx = 0;
    cur = mseq[midx[1:0]];
    ebus_din = '0;
    if (status_mode) ebus_din = 6'b101010;
    else if (diag_read && diag_ds == 7'o101) ebus_din = cur[5:0];
    else if (diag_read && diag_ds == 7'o100) ebus_din = {3'b101, cur[7:6], 1'b1};
  end

  // Strobe monitor: logs ds/dout at each strobe rise, strobe widths, and
  // low-gap lengths preceding each rise.
  logic       prev_st = 1'b0;
  int         cur_w = 0;
  int         low_run = 0;
  logic [6:0] ds_log [$];
  logic [3:0] dout_log [$];
  int         wid_log [$];
  int         gap_log [$];

  always @(negedge clk) begin
    if (diag_strobe && !prev_st) begin
      ds_log.push_back(diag_ds);
      dout_log.push_back(ebus_dout);
      gap_log.push_back(low_run);
      cur_w = 1;
    end else if (diag_strobe) begin
      cur_w++;
    end else if (prev_st) begin
      wid_log.push_back(cur_w);
      if (ds_log[$] == 7'o100) n100++;
      low_run = 1;
    end else begin
      low_run++;
    end
    prev_st = diag_strobe;
  end

  logic [12:0] tr_fn [64];
  logic        tr_st [64];
  logic        tr_rdy [64];
  int          lat;
  logic [7:0]  rsp_d;
  logic        rsp_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Called at a negedge; returns at the first negedge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    chk("ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Latency is numbered with the accept cycle as cycle 1.
  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    int n;
    issue(op, arg);
    lat = 0;
    n = 2;
    while (n < 300) begin
      if (n < 64) begin
        tr_fn[n]  = {diag_read, ebus_drive, ebus_dout, diag_ds};
        tr_st[n]  = diag_strobe;
        tr_rdy[n] = cmd_ready;
      end
      if (rsp_valid) begin
        lat   = n;
        rsp_d = rsp_data;
        rsp_e = rsp_err;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (lat == 0) begin
      chk("rsp_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("ready_after_done", cmd_ready, 1);
    end
  endtask

  function automatic logic [6:0] exp_ds(int i, int pairs);
    if (i == 0) return 7'o042;
    if (i == 1) return 7'o043;
    if (i == 2) return 7'o005;
    if (i < 3 + 2 * pairs) return ((i - 3) % 2 == 0) ? 7'o101 : 7'o100;
    return 7'o000;
  endfunction

  task automatic chk_burst(input string t, input int base, input int total, input int pairs);
    int badw, badg;
    logic [6:0] got;
    chk({t, "_nstrobes"}, ds_log.size() - base, total);
    for (int i = 0; i < total; i++) begin
      got = (base + i < ds_log.size()) ? ds_log[base + i] : 7'h7f;
      chk($sformatf("%s_ds%0d", t, i), got, exp_ds(i, pairs));
    end
    badw = 0;
    badg = 0;
    for (int i = 0; i < total; i++) begin
      if (base + i >= wid_log.size() || wid_log[base + i] != 2) badw++;
      if (i > 0 && (base + i >= gap_log.size() || gap_log[base + i] != 4)) badg++;
    end
    chk({t, "_bad_widths"}, badw, 0);
    chk({t, "_bad_gaps"}, badg, 0);
  endtask

  initial begin
    int base;
    int seen;
    int found;

    FPGA_RESET = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_arg    = '0;
    mseq[0] = 8'h00; mseq[1] = 8'h00; mseq[2] = 8'h00; mseq[3] = 8'h00;
    repeat (3) @(negedge clk);
    FPGA_RESET = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ds", diag_ds, 0);
    chk("rst_strobe", diag_strobe, 0);
    chk("rst_drive", ebus_drive, 0);
    chk("rst_dout", ebus_dout, 0);
    chk("rst_read", diag_read, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // 1: START
    send(3'd0, 8'h00);
    chk("start_latency", lat, 7);
    chk("start_ready_drop", tr_rdy[2], 0);
    chk("start_fn", tr_fn[2], {1'b0, 1'b0, 4'h0, 7'o001});
    chk("start_strobe_shape", {tr_st[2], tr_st[3], tr_st[4], tr_st[5], tr_st[6]}, 5'b00110);
    chk("start_err", rsp_e, 0);

    // 2: SET_SRC_RATE, fields stable SETUP..HOLD
    send(3'd4, 8'h06);
    chk("src_latency", lat, 7);
    for (int n = 2; n <= 6; n++)
      chk($sformatf("src_fn_c%0d", n), tr_fn[n], {1'b0, 1'b1, 4'b0110, 7'o044});
    chk("src_strobe_shape", {tr_st[3], tr_st[4], tr_st[5], tr_st[6]}, 4'b0110);

    // 3: BURST 0x25, counter drains 25 -> 10 -> 00
    mseq[0] = 8'h25; mseq[1] = 8'h10; mseq[2] = 8'h00; mlen = 3;
    base100 = n100;
    base = ds_log.size();
    send(3'd3, 8'h25);
    chk_burst("b25", base, 9, 3);
    chk("b25_dout042", dout_log[base], 4'h5);
    chk("b25_dout043", dout_log[base + 1], 4'h2);
    chk("b25_latency", lat, 56);
    chk("b25_rsp_data", rsp_d, 8'h00);
    chk("b25_rsp_err", rsp_e, 0);

    // BURST 0: only the two loads, then respond
    base = ds_log.size();
    send(3'd3, 8'h00);
    chk_burst("b00", base, 2, 0);
    chk("b00_latency", lat, 13);
    chk("b00_rsp_data", rsp_d, 8'h00);
    chk("b00_rsp_err", rsp_e, 0);

    // 4: BURST 0x01, counter stuck at 1 -> 4 pairs, STOP, timeout
    mseq[0] = 8'h01; mlen = 1;
    base100 = n100;
    base = ds_log.size();
    send(3'd3, 8'h01);
    chk_burst("b01", base, 12, 4);
    chk("b01_dout042", dout_log[base], 4'h1);
    chk("b01_dout043", dout_log[base + 1], 4'h0);
    chk("b01_latency", lat, 73);
    chk("b01_rsp_data", rsp_d, 8'h01);
    chk("b01_rsp_err", rsp_e, 1);

    // 5: READ_STATUS select 3
    status_mode = 1'b1;
    send(3'd7, 8'h03);
    status_mode = 1'b0;
    chk("rd_fn", tr_fn[2], {1'b1, 1'b0, 4'h0, 7'o103});
    chk("rd_fn_hold", tr_fn[6], {1'b1, 1'b0, 4'h0, 7'o103});
    chk("rd_latency", lat, 7);
    chk("rd_rsp_data", rsp_d, 8'h2A);
    chk("rd_rsp_err", rsp_e, 0);

    // 6: reset during the 043 strobe aborts without a response
    mseq[0] = 8'h25; mlen = 1;
    base100 = n100;
    issue(3'd3, 8'h25);
    found = 0;
    for (int n = 0; n < 100; n++) begin
      if (diag_strobe && diag_ds == 7'o043) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_found_043", found, 1);
    FPGA_RESET = 1'b1;
    @(negedge clk);
    FPGA_RESET = 1'b0;
    chk("rst_mid_strobe", diag_strobe, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_ds", diag_ds, 0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", seen, 0);
    send(3'd0, 8'h00);
    chk("post_rst_latency", lat, 7);
    chk("post_rst_fn", tr_fn[2], {1'b0, 1'b0, 4'h0, 7'o001});
    chk("post_rst_err", rsp_e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_diag_seq.md
Name: clk_diag_seq

Overview:
- Front-end diagnostic sequencer directly upstream of the M8526 CLK board.
- Turns one high-level clock command into the ordered EBUS diagnostic function cycles the CLK board decodes:
  - CTL functions 000-007
  - load functions 042-047
  - read functions 100-107
- For burst commands, loads the 8-bit burst counter, fires BURST, then polls the counter back through diag reads until it reaches zero or times out.

Parameters:
- SETUP_CYC, 2, cycles DS/data are stable before the strobe rises
- STROBE_CYC, 2, cycles the strobe stays high
- HOLD_CYC, 1, cycles DS/data are held after the strobe falls
- POLL_LIMIT, 1024, maximum poll reads before a timeout error

Ports:
- clk  in  1  system clock
- FPGA_RESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, command accepted on valid&ready
- cmd_op  in  3  0=START 1=STOP 2=SINGLE_STEP 3=BURST 4=SET_SRC_RATE 5=CLR_RESET 6=SET_RESET 7=READ_STATUS
- cmd_arg  in  8  burst count (BURST); {src[1:0],rate[1:0]} in [3:0] (SET_SRC_RATE); read select in [2:0] (READ_STATUS)
- diag_ds  out  7  EBUS DS[0:6] function code
- diag_strobe  out  1  EBUS diag strobe
- ebus_drive  out  1  sequencer drives EBUS data[32:35]
- ebus_dout  out  4  EBUS data[32:35] for load functions
- diag_read  out  1  read function active
- ebus_din  in  6  EBUS data[30:35] returned by the CLK board
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read value, or final burst count
- rsp_err  out  1  timeout flag, valid with rsp_valid

Behaviour:
- Reset values: cmd_ready=1; diag_ds=0; diag_strobe=0; ebus_drive=0; ebus_dout=0; diag_read=0; rsp_valid=0; rsp_data=0; rsp_err=0; FSM=IDLE.
- Reset mid-sequence aborts immediately: strobe drops the same cycle reset is sampled, and no rsp_valid is produced.
- FSM states: IDLE, SETUP, STROBE, HOLD, NEXT, POLL_SAMPLE, DONE.
- One function cycle is SETUP (SETUP_CYC) -> STROBE (STROBE_CYC, diag_strobe=1) -> HOLD (HOLD_CYC).
  - diag_ds, ebus_dout, ebus_drive and diag_read are constant across the whole cycle.
- A command is accepted only in IDLE with cmd_valid=1.
  - cmd_op and cmd_arg are latched; cmd_ready drops the next cycle.
  - cmd_valid while busy is ignored (not queued).
- Step lists (octal function codes):
  - START: 001
  - STOP: 000
  - SINGLE_STEP: 002
  - CLR_RESET: 006
  - SET_RESET: 007
  - SET_SRC_RATE: 044 with dout=arg[3:0], drive=1
  - READ_STATUS: read 10s, where s=arg[2:0]; diag_read=1, drive=0.
    - ebus_din is sampled in the last STROBE cycle.
    - rsp_data={2'b0,din}.
  - BURST:
    - 042 with dout=arg[3:0]
    - 043 with dout=arg[7:4]
    - 005
    - then poll loop.
- Poll loop (BURST only):
  - Read 101 and sample count[2:7]=din[30:35].
  - Read 100 and sample count[0:1]=din[33:34].
  - Loop ends when the assembled 8-bit count is 0: rsp_data=0, rsp_err=0.
  - Otherwise repeat; the poll counter increments once per 101+100 pair.
  - When the poll counter reaches POLL_LIMIT, issue STOP (000), then respond with rsp_err=1 and rsp_data=last count.
- BURST with arg=0: skip 005 and the poll loop; respond after 043 with rsp_data=0, rsp_err=0.
- DONE: rsp_valid=1 for exactly one cycle. The cycle after, the FSM returns to IDLE and cmd_ready=1.
- Between function cycles there is exactly one NEXT cycle with diag_strobe=0 and ds unchanged. Back-to-back strobes are therefore never adjacent.
- Minimum latency, single-function command: 1 (accept) + SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 (DONE); default = 7 cycles from accept to rsp_valid.
- The poll counter width is clog2(POLL_LIMIT)+1 and saturates, never wraps.

Test Plan:
1. Reset, then START (op=0) -> diag_ds=001 with strobe high for 2 cycles; rsp_valid 7 cycles after accept; rsp_err=0.
2. SET_SRC_RATE arg=8'h06 -> ds=044, ebus_drive=1, ebus_dout=4'b0110 stable from SETUP through HOLD; strobe width 2.
3. BURST arg=8'h25; model returns count 8'h25, then 8'h10, then 0 -> sequence 042(dout=5), 043(dout=2), 005, then poll pairs 101/100 until 0; rsp_data=0, rsp_err=0.
4. BURST arg=8'h01, POLL_LIMIT=4, model stuck at 8'h01 -> exactly 4 poll pairs, then ds=000 strobe; rsp_err=1, rsp_data=8'h01.
5. READ_STATUS arg=3'b011, ebus_din=6'b101010 -> diag_read=1, ds=103, ebus_drive=0; rsp_data=8'h2A.
6. FPGA_RESET asserted during the strobe of 043 -> strobe=0 and cmd_ready=1 next cycle; no rsp_valid; a new START completes normally.
